// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared types for the digit-serial word comparator
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    st_equal       = 2'b00,
    st_a_less_b    = 2'b01,
    st_a_greater_b = 2'b10
  } cmp_state_t;

  typedef struct packed {
    logic less;
    logic eq;
    logic greater;
  } cmp_result_t;

  function automatic cmp_result_t state_to_result(input cmp_state_t s);
    cmp_result_t r;
    r.less    = (s == st_a_less_b);
    r.eq      = (s == st_equal);
    r.greater = (s == st_a_greater_b);
    return r;
  endfunction

endpackage

// File: rtl/serial_digit_compare.sv
// rtl/serial_digit_compare.sv - combinational unsigned/signed digit compare
// SERIAL_WORD_COMPARATOR_SIGNED_EN flips the MSB of the sign digit so two's complement orders correctly.
module serial_digit_compare #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               is_sign_digit,
  output logic               lt,
  output logic               gt
);

  logic [DIGIT_W-1:0] a_x;
  logic [DIGIT_W-1:0] b_x;

`ifdef SERIAL_WORD_COMPARATOR_SIGNED_EN
  always_comb begin
    a_x = a;
    b_x = b;
    if (is_sign_digit) begin
      a_x[DIGIT_W-1] = ~a[DIGIT_W-1];
      b_x[DIGIT_W-1] = ~b[DIGIT_W-1];
    end
  end
`else
  logic unused_sign_digit;
  assign unused_sign_digit = is_sign_digit;
  assign a_x = a;
  assign b_x = b;
`endif

  assign lt = (a_x < b_x);
  assign gt = (a_x > b_x);

endmodule

// File: rtl/serial_word_comparator.sv
// rtl/serial_word_comparator.sv - digit-serial framed-word magnitude comparator
// Optional two's complement compare via SERIAL_WORD_COMPARATOR_SIGNED_EN.
module serial_word_comparator
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W     = 1,
  parameter int WORD_DIGITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               msb_first,
  input  logic               abort,
  output logic               busy,
  output logic               res_valid,
  output logic               res_less,
  output logic               res_eq,
  output logic               res_greater
);

  localparam int CNT_W = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic             order_q;
  cmp_state_t       state_q;
  cmp_state_t       state_cur;
  cmp_state_t       state_nxt;
  cmp_result_t      res_q;
  logic             res_valid_q;
  logic             first;
  logic             last;
  logic             order_eff;
  logic             is_sign_digit;
  logic             lt;
  logic             gt;

  assign first = (cnt == '0);
  assign last  = (cnt == LAST_CNT);

  // The first digit uses the live order bit and an implicit equal history,
  // so a word can start directly after the previous one finished.
  assign order_eff     = first ? msb_first : order_q;
  assign state_cur     = first ? st_equal : state_q;
  assign is_sign_digit = order_eff ? first : last;

  serial_digit_compare #(
    .DIGIT_W(DIGIT_W)
  ) u_digit_compare (
    .a            (a),
    .b            (b),
    .is_sign_digit(is_sign_digit),
    .lt           (lt),
    .gt           (gt)
  );

  always_comb begin
    state_nxt = state_cur;
    if (order_eff) begin
      if (state_cur == st_equal) begin
        if (lt) begin
          state_nxt = st_a_less_b;
        end else if (gt) begin
          state_nxt = st_a_greater_b;
        end
      end
    end else begin
      if (lt) begin
        state_nxt = st_a_less_b;
      end else if (gt) begin
        state_nxt = st_a_greater_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      order_q     <= 1'b1;
      state_q     <= st_equal;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      if (abort) begin
        cnt     <= '0;
        state_q <= st_equal;
      end else if (in_valid) begin
        if (first) begin
          order_q <= msb_first;
        end
        if (last) begin
          cnt         <= '0;
          state_q     <= st_equal;
          res_q       <= state_to_result(state_nxt);
          res_valid_q <= 1'b1;
        end else begin
          cnt     <= cnt + CNT_W'(1);
          state_q <= state_nxt;
        end
      end
    end
  end

  assign busy        = (cnt != '0);
  assign res_valid   = res_valid_q;
  assign res_less    = res_q.less;
  assign res_eq      = res_q.eq;
  assign res_greater = res_q.greater;

endmodule
